// File: rtl/mem_req_arbiter_if.sv
// rtl/mem_req_arbiter_if.sv - requester and AXI-master-user signal bundle for mem_req_arbiter
interface mem_req_arbiter_if;
    // fetch port
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;

    // load/store port
    logic        ls_req;
    logic        ls_we;
    logic [1:0]  ls_size;
    logic        ls_unsigned;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_ack;
    logic [31:0] ls_rdata;
    logic        ls_misalign;

    // AXI master start/done user side
    logic        m_start;
    logic        m_rw;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_done;
    logic [31:0] m_rdata;
    logic        m_busy;

    modport master (
        input  if_req, if_addr,
        input  ls_req, ls_we, ls_size, ls_unsigned, ls_addr, ls_wdata,
        input  m_done, m_rdata, m_busy,
        output if_ack, if_rdata,
        output ls_ack, ls_rdata, ls_misalign,
        output m_start, m_rw, m_addr, m_wdata, m_wstrb
    );

    modport slave (
        output if_req, if_addr,
        output ls_req, ls_we, ls_size, ls_unsigned, ls_addr, ls_wdata,
        output m_done, m_rdata, m_busy,
        input  if_ack, if_rdata,
        input  ls_ack, ls_rdata, ls_misalign,
        input  m_start, m_rw, m_addr, m_wdata, m_wstrb
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - IF/LSU arbiter, store lane alignment and load formatting in front of the AXI master
module mem_req_arbiter (
    input  logic              clk,
    input  logic              rst_n,
    mem_req_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic GRANT_IF = 1'b0;
    localparam logic GRANT_LS = 1'b1;

    function automatic logic [1:0] eff_size(input logic [1:0] size);
        return (size == 2'd3) ? 2'd2 : size;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        logic [1:0] es;
        es = eff_size(size);
        return ((es == 2'd1) && off[0]) || ((es == 2'd2) && (off != 2'd0));
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] r;
        case (eff_size(size))
            2'd0:    r = {4{wdata[7:0]}};
            2'd1:    r = {2{wdata[15:0]}};
            default: r = wdata;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] r;
        case (eff_size(size))
            2'd0:    r = 4'b0001 << off;
            2'd1:    r = 4'b0011 << off;
            default: r = 4'b1111;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_data(input logic [1:0] size, input logic uns,
                                              input logic [1:0] off, input logic [31:0] rdata);
        logic [31:0] b_sh;
        logic [31:0] h_sh;
        logic [31:0] r;
        b_sh = rdata >> {off, 3'b000};
        h_sh = rdata >> {off[1], 4'b0000};
        case (eff_size(size))
            2'd0:    r = uns ? {24'b0, b_sh[7:0]}  : {{24{b_sh[7]}}, b_sh[7:0]};
            2'd1:    r = uns ? {16'b0, h_sh[15:0]} : {{16{h_sh[15]}}, h_sh[15:0]};
            default: r = rdata;
        endcase
        return r;
    endfunction

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_grant_q, last_grant_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        unsigned_q, unsigned_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic        if_ack_q, if_ack_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic        ls_ack_q, ls_ack_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;
    logic        ls_misalign_q, ls_misalign_d;
    logic        m_start_q, m_start_d;
    logic        m_rw_q, m_rw_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic [3:0]  m_wstrb_q, m_wstrb_d;

    logic        any_req;
    logic        pick_ls;
    logic        src_we;
    logic [1:0]  src_size;
    logic [31:0] src_addr;
    logic [31:0] src_wdata;
    logic        issue_now;

    assign any_req = bus.if_req | bus.ls_req;
    // On a tie the port that did not win last time gets the grant.
    assign pick_ls = bus.ls_req & (~bus.if_req | (last_grant_q == GRANT_IF));

    // In IDLE the issue can go out straight from the incoming request;
    // afterwards it is taken from the latched copy.
    always_comb begin
        src_we    = we_q;
        src_size  = size_q;
        src_addr  = addr_q;
        src_wdata = wdata_q;
        if (state_q == S_IDLE) begin
            src_we    = pick_ls & bus.ls_we;
            src_size  = pick_ls ? bus.ls_size : 2'd2;
            src_addr  = pick_ls ? bus.ls_addr : {bus.if_addr[31:2], 2'b00};
            src_wdata = pick_ls ? bus.ls_wdata : 32'h0;
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_grant_d  = last_grant_q;
        we_d          = we_q;
        size_d        = size_q;
        unsigned_d    = unsigned_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        if_ack_d      = 1'b0;
        if_rdata_d    = if_rdata_q;
        ls_ack_d      = 1'b0;
        ls_rdata_d    = ls_rdata_q;
        ls_misalign_d = 1'b0;
        m_start_d     = 1'b0;
        m_rw_d        = m_rw_q;
        m_addr_d      = m_addr_q;
        m_wdata_d     = m_wdata_q;
        m_wstrb_d     = m_wstrb_q;
        issue_now     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    last_grant_d = pick_ls;
                    owner_d      = pick_ls;
                    we_d         = src_we;
                    size_d       = src_size;
                    unsigned_d   = bus.ls_unsigned;
                    addr_d       = src_addr;
                    wdata_d      = src_wdata;
                    if (pick_ls && misaligned(bus.ls_size, bus.ls_addr[1:0])) begin
                        ls_ack_d      = 1'b1;
                        ls_misalign_d = 1'b1;
                        ls_rdata_d    = 32'h0;
                        state_d       = S_RESP;
                    end else begin
                        state_d   = S_ISSUE;
                        issue_now = ~bus.m_busy;
                    end
                end
            end
            S_ISSUE: begin
                // m_start_q high means the pulse is out this cycle.
                if (m_start_q) begin
                    state_d = S_WAIT;
                end else begin
                    issue_now = ~bus.m_busy;
                end
            end
            S_WAIT: begin
                if (bus.m_done) begin
                    state_d = S_RESP;
                    if (owner_q == GRANT_LS) begin
                        ls_ack_d   = 1'b1;
                        ls_rdata_d = we_q ? 32'h0
                                          : load_data(size_q, unsigned_q, addr_q[1:0], bus.m_rdata);
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = bus.m_rdata;
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (issue_now) begin
            m_start_d = 1'b1;
            m_rw_d    = src_we;
            m_addr_d  = {src_addr[31:2], 2'b00};
            m_wstrb_d = src_we ? store_strb(src_size, src_addr[1:0]) : 4'b0000;
            if (src_we) begin
                m_wdata_d = store_data(src_size, src_wdata);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            owner_q       <= GRANT_IF;
            last_grant_q  <= GRANT_LS;
            we_q          <= 1'b0;
            size_q        <= 2'd0;
            unsigned_q    <= 1'b0;
            addr_q        <= 32'h0;
            wdata_q       <= 32'h0;
            if_ack_q      <= 1'b0;
            if_rdata_q    <= 32'h0;
            ls_ack_q      <= 1'b0;
            ls_rdata_q    <= 32'h0;
            ls_misalign_q <= 1'b0;
            m_start_q     <= 1'b0;
            m_rw_q        <= 1'b0;
            m_addr_q      <= 32'h0;
            m_wdata_q     <= 32'h0;
            m_wstrb_q     <= 4'b0000;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_grant_q  <= last_grant_d;
            we_q          <= we_d;
            size_q        <= size_d;
            unsigned_q    <= unsigned_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            if_ack_q      <= if_ack_d;
            if_rdata_q    <= if_rdata_d;
            ls_ack_q      <= ls_ack_d;
            ls_rdata_q    <= ls_rdata_d;
            ls_misalign_q <= ls_misalign_d;
            m_start_q     <= m_start_d;
            m_rw_q        <= m_rw_d;
            m_addr_q      <= m_addr_d;
            m_wdata_q     <= m_wdata_d;
            m_wstrb_q     <= m_wstrb_d;
        end
    end

    assign bus.if_ack      = if_ack_q;
    assign bus.if_rdata    = if_rdata_q;
    assign bus.ls_ack      = ls_ack_q;
    assign bus.ls_rdata    = ls_rdata_q;
    assign bus.ls_misalign = ls_misalign_q;
    assign bus.m_start     = m_start_q;
    assign bus.m_rw        = m_rw_q;
    assign bus.m_addr      = m_addr_q;
    assign bus.m_wdata     = m_wdata_q;
    assign bus.m_wstrb     = m_wstrb_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb/tb_mem_req_arbiter.sv - self-checking bench for mem_req_arbiter with a word-memory responder and reference model
module tb_mem_req_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_req_arbiter_if bus();
    mem_req_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          cyc;
    } start_t;

    start_t      start_log[$];
    logic [31:0] resp_mem[int];
    logic [31:0] model_mem[int];
    logic        resp_busy = 1'b0;
    logic        resp_done = 1'b0;
    logic        force_busy = 1'b0;
    logic [31:0] resp_rdata = 32'h0;
    int          resp_lat = 1;
    int          last_done_cyc = -1;

    assign bus.m_busy  = resp_busy | force_busy;
    assign bus.m_done  = resp_done;
    assign bus.m_rdata = resp_rdata;

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        int k;
        k = int'(a >> 2);
        return model_mem.exists(k) ? model_mem[k] : 32'h0;
    endfunction

    task automatic mem_write(input logic [31:0] a, input logic [31:0] v);
        resp_mem[int'(a >> 2)]  = v;
        model_mem[int'(a >> 2)] = v;
    endtask

    // Behaves as the downstream AXI master: one transaction, fixed latency, busy while active.
    initial begin : responder
        int          cnt;
        int          k;
        logic        pend;
        logic [31:0] rd;
        logic [31:0] w;
        pend = 1'b0;
        cnt  = 0;
        rd   = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            resp_done = 1'b0;
            if (pend) begin
                if (cnt <= 0) begin
                    resp_done     = 1'b1;
                    resp_rdata    = rd;
                    resp_busy     = 1'b0;
                    pend          = 1'b0;
                    last_done_cyc = cyc;
                end else begin
                    cnt--;
                end
            end else if (bus.m_start) begin
                start_log.push_back('{bus.m_rw, bus.m_addr, bus.m_wdata, bus.m_wstrb, cyc});
                k = int'(bus.m_addr >> 2);
                w = resp_mem.exists(k) ? resp_mem[k] : 32'h0;
                if (bus.m_rw) begin
                    for (int b = 0; b < 4; b++)
                        if (bus.m_wstrb[b]) w[8*b +: 8] = bus.m_wdata[8*b +: 8];
                    resp_mem[k] = w;
                    rd = $urandom;
                end else begin
                    rd = w;
                end
                pend      = 1'b1;
                cnt       = resp_lat;
                resp_busy = 1'b1;
            end
        end
    end

    task automatic ls_txn(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic ok, output logic [31:0] rdata, output logic mis,
                          output int req_cyc, output int ack_cyc);
        @(posedge clk);
        #1;
        bus.ls_we = we; bus.ls_size = size; bus.ls_unsigned = uns;
        bus.ls_addr = addr; bus.ls_wdata = wdata; bus.ls_req = 1'b1;
        req_cyc = cyc; ok = 1'b0; rdata = 32'h0; mis = 1'b0; ack_cyc = -1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (bus.ls_ack) begin
                ok = 1'b1; rdata = bus.ls_rdata; mis = bus.ls_misalign; ack_cyc = cyc;
                break;
            end
        end
        bus.ls_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic if_txn(input logic [31:0] addr, output logic ok, output logic [31:0] rdata,
                          output int req_cyc, output int ack_cyc);
        @(posedge clk);
        #1;
        bus.if_addr = addr; bus.if_req = 1'b1;
        req_cyc = cyc; ok = 1'b0; rdata = 32'h0; ack_cyc = -1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (bus.if_ack) begin
                ok = 1'b1; rdata = bus.if_rdata; ack_cyc = cyc;
                break;
            end
        end
        bus.if_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [136:0] outs;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        outs = {bus.if_ack, bus.ls_ack, bus.ls_misalign, bus.m_start, bus.m_rw, bus.m_addr,
                bus.m_wdata, bus.m_wstrb, bus.if_rdata, bus.ls_rdata};
        n_cmp++; if (outs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", outs); end
        rst_n = 1'b1;
    endtask

    task automatic test_if_fetch();
        logic ok; logic [31:0] rd; int rc, ac;
        resp_lat = 2;
        start_log.delete();
        if_txn(32'h0000_1003, ok, rd, rc, ac);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL if_ack_seen: got %b want 1", ok); end
        n_cmp++; if (start_log.size() !== 1) begin n_fail++; $display("FAIL if_start_count: got %0d want 1", start_log.size()); end
        if (start_log.size() == 1) begin
            n_cmp++; if ({start_log[0].rw, start_log[0].addr, start_log[0].strb} !== {1'b0, 32'h0000_1000, 4'h0}) begin
                n_fail++; $display("FAIL if_m_fields: got rw=%b addr=%h strb=%h want 0/00001000/0", start_log[0].rw, start_log[0].addr, start_log[0].strb); end
            n_cmp++; if (start_log[0].cyc !== rc + 1) begin n_fail++; $display("FAIL if_start_latency: got %0d want %0d", start_log[0].cyc, rc + 1); end
        end
        n_cmp++; if (rd !== 32'h1122_3344) begin n_fail++; $display("FAIL if_rdata: got %h want 11223344", rd); end
        n_cmp++; if (ac !== last_done_cyc + 1) begin n_fail++; $display("FAIL if_ack_latency: got %0d want %0d", ac, last_done_cyc + 1); end
    endtask

    task automatic test_load_format();
        logic ok, mis; logic [31:0] rd; int rc, ac;
        resp_lat = 1;
        ls_txn(1'b0, 2'd0, 1'b0, 32'h0000_2002, 32'h0, ok, rd, mis, rc, ac);
        n_cmp++; if ({ok, mis, rd} !== {1'b1, 1'b0, 32'hFFFF_FF80}) begin n_fail++; $display("FAIL lb_signed: got ok=%b mis=%b %h want 1/0/ffffff80", ok, mis, rd); end
        ls_txn(1'b0, 2'd0, 1'b1, 32'h0000_2002, 32'h0, ok, rd, mis, rc, ac);
        n_cmp++; if ({ok, mis, rd} !== {1'b1, 1'b0, 32'h0000_0080}) begin n_fail++; $display("FAIL lb_unsigned: got ok=%b mis=%b %h want 1/0/00000080", ok, mis, rd); end
    endtask

    task automatic test_half_store();
        logic ok, mis; logic [31:0] rd; int rc, ac;
        resp_lat = 3;
        start_log.delete();
        ls_txn(1'b1, 2'd1, 1'b0, 32'h0000_3002, 32'hDEAD_BEEF, ok, rd, mis, rc, ac);
        n_cmp++; if ({ok, mis, rd} !== {1'b1, 1'b0, 32'h0}) begin n_fail++; $display("FAIL sh_ack: got ok=%b mis=%b %h want 1/0/0", ok, mis, rd); end
        n_cmp++; if (start_log.size() !== 1) begin n_fail++; $display("FAIL sh_start_count: got %0d want 1", start_log.size()); end
        if (start_log.size() == 1) begin
            n_cmp++; if ({start_log[0].rw, start_log[0].addr, start_log[0].wdata, start_log[0].strb} !== {1'b1, 32'h0000_3000, 32'hBEEF_BEEF, 4'b1100}) begin
                n_fail++; $display("FAIL sh_m_fields: got rw=%b addr=%h wdata=%h strb=%b", start_log[0].rw, start_log[0].addr, start_log[0].wdata, start_log[0].strb); end
        end
        n_cmp++; if (ac !== last_done_cyc + 1) begin n_fail++; $display("FAIL sh_ack_latency: got %0d want %0d", ac, last_done_cyc + 1); end
    endtask

    task automatic test_misalign();
        logic ok, mis; logic [31:0] rd; int rc, ac;
        start_log.delete();
        ls_txn(1'b0, 2'd2, 1'b0, 32'h0000_4001, 32'h0, ok, rd, mis, rc, ac);
        repeat (2) @(negedge clk);
        n_cmp++; if ({ok, mis, rd} !== {1'b1, 1'b1, 32'h0}) begin n_fail++; $display("FAIL lw_misalign: got ok=%b mis=%b %h want 1/1/0", ok, mis, rd); end
        n_cmp++; if (ac !== rc + 1) begin n_fail++; $display("FAIL misalign_latency: got %0d want %0d", ac, rc + 1); end
        n_cmp++; if (start_log.size() !== 0) begin n_fail++; $display("FAIL misalign_no_start: got %0d starts want 0", start_log.size()); end
    endtask

    task automatic test_busy_stall();
        logic ok; logic [31:0] rd; int viol, rel;
        resp_lat = 0;
        start_log.delete();
        force_busy = 1'b1;
        @(posedge clk);
        #1;
        bus.ls_we = 1'b0; bus.ls_size = 2'd2; bus.ls_unsigned = 1'b0; bus.ls_addr = 32'h0000_2000; bus.ls_req = 1'b1;
        viol = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (bus.m_start) viol++;
        end
        force_busy = 1'b0;
        rel = cyc;
        ok = 1'b0; rd = 32'h0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (bus.ls_ack) begin ok = 1'b1; rd = bus.ls_rdata; break; end
        end
        bus.ls_req = 1'b0;
        @(negedge clk);
        n_cmp++; if (viol !== 0) begin n_fail++; $display("FAIL busy_no_start: got %0d starts while busy want 0", viol); end
        n_cmp++; if ({ok, rd} !== {1'b1, 32'h0080_0000}) begin n_fail++; $display("FAIL busy_load: got ok=%b %h want 1/00800000", ok, rd); end
        n_cmp++; if (start_log.size() !== 1 || start_log[0].cyc !== rel + 1) begin
            n_fail++; $display("FAIL busy_start_cycle: got n=%0d cyc=%0d want 1/%0d", start_log.size(), (start_log.size() > 0) ? start_log[0].cyc : -1, rel + 1); end
    endtask

    task automatic test_tie_alternation();
        int order[$]; logic [31:0] dat[$]; logic if_prev, ls_prev; int dbl, extra;
        logic [31:0] want;
        resp_lat = 1;
        rst_n = 1'b0;
        bus.if_req = 1'b0; bus.ls_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.if_addr = 32'h0000_1000;
        bus.ls_we = 1'b0; bus.ls_size = 2'd2; bus.ls_unsigned = 1'b0; bus.ls_addr = 32'h0000_2000;
        bus.if_req = 1'b1; bus.ls_req = 1'b1;
        #2 rst_n = 1'b1;
        dbl = 0; extra = 0; if_prev = 1'b0; ls_prev = 1'b0;
        for (int i = 0; i < 200 && order.size() < 4; i++) begin
            @(posedge clk);
            #1;
            if (bus.if_ack && bus.ls_ack) dbl++;
            if (bus.if_ack) begin if (if_prev) dbl++; order.push_back(0); dat.push_back(bus.if_rdata); end
            if (bus.ls_ack) begin if (ls_prev) dbl++; order.push_back(1); dat.push_back(bus.ls_rdata); end
            if_prev = bus.if_ack; ls_prev = bus.ls_ack;
        end
        bus.if_req = 1'b0; bus.ls_req = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus.if_ack || bus.ls_ack) extra++;
        end
        n_cmp++; if (order.size() !== 4) begin n_fail++; $display("FAIL tie_ack_count: got %0d want 4", order.size()); end
        for (int i = 0; i < order.size(); i++) begin
            want = (i % 2 == 0) ? 32'h1122_3344 : 32'h0080_0000;
            n_cmp++; if (order[i] !== i % 2) begin n_fail++; $display("FAIL tie_order[%0d]: got port %0d want %0d", i, order[i], i % 2); end
            n_cmp++; if (dat[i] !== want) begin n_fail++; $display("FAIL tie_rdata[%0d]: got %h want %h", i, dat[i], want); end
        end
        n_cmp++; if (dbl + extra !== 0) begin n_fail++; $display("FAIL tie_double_ack: got %0d extra acks want 0", dbl + extra); end
    endtask

    task automatic test_random();
        logic ok, mis, we, uns, mis_exp;
        logic [31:0] rd, a, wd, w, ew, exp_rd;
        logic [1:0] sz, es, off;
        logic [3:0] estrb;
        int rc, ac, k;
        for (int i = 0; i < 64; i++) mem_write(32'h5000 + 32'(4 * i), $urandom);
        for (int t = 0; t < 60; t++) begin
            resp_lat = $urandom_range(0, 3);
            a = 32'h5000 + 32'($urandom_range(0, 63));
            start_log.delete();
            if ($urandom_range(0, 3) == 0) begin
                if_txn(a, ok, rd, rc, ac);
                exp_rd = model_rd(a & ~32'h3);
                n_cmp++; if ({ok, rd} !== {1'b1, exp_rd}) begin n_fail++; $display("FAIL rnd_if[%0d]: addr %h got ok=%b %h want %h", t, a, ok, rd, exp_rd); end
                n_cmp++; if (start_log.size() !== 1 || start_log[0].addr !== (a & ~32'h3) || start_log[0].rw !== 1'b0) begin
                    n_fail++; $display("FAIL rnd_if_start[%0d]: addr %h bad start (n=%0d)", t, a, start_log.size()); end
            end else begin
                we = 1'($urandom_range(0, 1)); sz = 2'($urandom_range(0, 3));
                uns = 1'($urandom_range(0, 1)); wd = $urandom;
                ls_txn(we, sz, uns, a, wd, ok, rd, mis, rc, ac);
                off = a[1:0];
                es = (sz == 2'd3) ? 2'd2 : sz;
                mis_exp = (es == 2'd1 && off[0]) || (es == 2'd2 && off != 2'd0);
                n_cmp++; if ({ok, mis} !== {1'b1, mis_exp}) begin n_fail++; $display("FAIL rnd_ls_ack[%0d]: addr %h size %0d got ok=%b mis=%b want 1/%b", t, a, sz, ok, mis, mis_exp); end
                if (mis_exp) begin
                    n_cmp++; if (rd !== 32'h0 || start_log.size() !== 0) begin n_fail++; $display("FAIL rnd_mis[%0d]: got rdata %h starts %0d want 0/0", t, rd, start_log.size()); end
                end else begin
                    w = model_rd(a);
                    if (we) begin
                        ew    = (es == 2'd0) ? wd[7:0] * 32'h0101_0101 : (es == 2'd1) ? wd[15:0] * 32'h0001_0001 : wd;
                        estrb = (es == 2'd0) ? 4'(1 << off) : (es == 2'd1) ? 4'(3 << off) : 4'hF;
                        for (int b = 0; b < 4; b++) if (estrb[b]) w[8*b +: 8] = ew[8*b +: 8];
                        k = int'(a >> 2);
                        model_mem[k] = w;
                        exp_rd = 32'h0;
                        n_cmp++; if (start_log.size() !== 1 || {start_log[0].rw, start_log[0].addr, start_log[0].wdata, start_log[0].strb} !== {1'b1, a & ~32'h3, ew, estrb}) begin
                            n_fail++; $display("FAIL rnd_store[%0d]: addr %h size %0d wd %h bad start (n=%0d) want wdata %h strb %b", t, a, sz, wd, start_log.size(), ew, estrb); end
                    end else begin
                        if (es == 2'd0) begin
                            exp_rd = (w >> (8 * off)) & 32'hFF;
                            if (!uns && exp_rd[7]) exp_rd = exp_rd | 32'hFFFF_FF00;
                        end else if (es == 2'd1) begin
                            exp_rd = (w >> (8 * off)) & 32'hFFFF;
                            if (!uns && exp_rd[15]) exp_rd = exp_rd | 32'hFFFF_0000;
                        end else begin
                            exp_rd = w;
                        end
                        n_cmp++; if (start_log.size() !== 1 || {start_log[0].rw, start_log[0].addr, start_log[0].strb} !== {1'b0, a & ~32'h3, 4'h0}) begin
                            n_fail++; $display("FAIL rnd_load_start[%0d]: addr %h bad start (n=%0d)", t, a, start_log.size()); end
                    end
                    n_cmp++; if (rd !== exp_rd) begin n_fail++; $display("FAIL rnd_rdata[%0d]: we=%b addr %h size %0d uns %b got %h want %h", t, we, a, sz, uns, rd, exp_rd); end
                    n_cmp++; if (ac !== last_done_cyc + 1) begin n_fail++; $display("FAIL rnd_ack_latency[%0d]: got %0d want %0d", t, ac, last_done_cyc + 1); end
                end
            end
        end
    endtask

    task automatic test_reset_in_wait();
        logic [136:0] outs; int acks, starts, started;
        resp_lat = 6;
        start_log.delete();
        @(posedge clk);
        #1;
        bus.if_addr = 32'h0000_1000; bus.if_req = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        started = start_log.size();
        rst_n = 1'b0;
        #1;
        outs = {bus.if_ack, bus.ls_ack, bus.ls_misalign, bus.m_start, bus.m_rw, bus.m_addr,
                bus.m_wdata, bus.m_wstrb, bus.if_rdata, bus.ls_rdata};
        bus.if_req = 1'b0;
        n_cmp++; if (started !== 1) begin n_fail++; $display("FAIL rst_wait_started: got %0d starts want 1", started); end
        n_cmp++; if (outs !== '0) begin n_fail++; $display("FAIL rst_wait_outputs: got %h want 0", outs); end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        acks = 0; starts = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (bus.if_ack || bus.ls_ack) acks++;
            if (bus.m_start) starts++;
        end
        n_cmp++; if ({acks, starts} !== {32'd0, 32'd0}) begin n_fail++; $display("FAIL rst_wait_late_done: got acks=%0d starts=%0d want 0/0", acks, starts); end
    endtask

    initial begin
        bus.if_req = 1'b0; bus.if_addr = 32'h0;
        bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_size = 2'd0; bus.ls_unsigned = 1'b0;
        bus.ls_addr = 32'h0; bus.ls_wdata = 32'h0;
        mem_write(32'h0000_1000, 32'h1122_3344);
        mem_write(32'h0000_2000, 32'h0080_0000);
        test_reset();
        test_if_fetch();
        test_load_format();
        test_half_store();
        test_misalign();
        test_busy_stall();
        test_tie_alternation();
        test_random();
        test_reset_in_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
